// File: rtl/input_debouncer_pkg.sv
// Shared types and defaults for the input debouncer and its users.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } debounce_state_e;

    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_STABLE_CYCLES = 16;

endpackage

// File: rtl/input_debouncer_if.sv
// Debouncer signal bundle; glitch_cnt and GLITCH_W exist only with DEBOUNCE_GLITCH_CNT_EN.
interface input_debouncer_if
`ifdef DEBOUNCE_GLITCH_CNT_EN
    #(parameter int GLITCH_W = 8)
`endif
    ;
    logic din_async;
    logic dout;
    logic busy;

`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [GLITCH_W-1:0] glitch_cnt;

    modport master (output din_async, input dout, input busy, input glitch_cnt);
    modport slave  (input din_async, output dout, output busy, output glitch_cnt);
`else
    modport master (output din_async, input dout, input busy);
    modport slave  (input din_async, output dout, output busy);
`endif

endinterface

// File: rtl/input_debouncer_sync_chain.sv
// N-flop synchronizer with synchronous active-low clear; reusable for any async input.
module sync_chain #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);
    logic [N-1:0] s;

    always_ff @(posedge clk) begin
        if (!resetn) s <= '0;
        else         s <= {s[N-2:0], d};
    end

    assign q = s[N-1];

endmodule

// File: rtl/input_debouncer.sv
// Synchronizes din_async and accepts a new level only after STABLE_CYCLES equal samples.
// Optional saturating reject counter enabled by DEBOUNCE_GLITCH_CNT_EN.
module input_debouncer
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    parameter int GLITCH_W      = 8
`endif
) (
    input  logic              clk,
    input  logic              resetn,
    input_debouncer_if.slave  dbif
);
    localparam int                CNT_W    = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    debounce_state_e  state;
    logic [CNT_W-1:0] cnt;
    logic             dout_q;
    logic             s_out;

    sync_chain #(.N(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (dbif.din_async),
        .q      (s_out)
    );

    // A revert seen on the terminal count still wins: the revert branch is tested first.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state  <= IDLE_LOW;
            cnt    <= '0;
            dout_q <= 1'b0;
        end else begin
            case (state)
                IDLE_LOW: if (s_out) begin
                    state <= WAIT_HIGH;
                    cnt   <= CNT_W'(1);
                end
                WAIT_HIGH: begin
                    if (!s_out) begin
                        state <= IDLE_LOW;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state  <= IDLE_HIGH;
                        dout_q <= 1'b1;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                IDLE_HIGH: if (!s_out) begin
                    state <= WAIT_LOW;
                    cnt   <= CNT_W'(1);
                end
                WAIT_LOW: begin
                    if (s_out) begin
                        state <= IDLE_HIGH;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state  <= IDLE_LOW;
                        dout_q <= 1'b0;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE_LOW;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign dbif.dout = dout_q;
    assign dbif.busy = (state == WAIT_HIGH) || (state == WAIT_LOW);

`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic                glitch_evt;
    logic [GLITCH_W-1:0] glitch_q;

    assign glitch_evt = ((state == WAIT_HIGH) && !s_out) || ((state == WAIT_LOW) && s_out);

    always_ff @(posedge clk) begin
        if (!resetn)                          glitch_q <= '0;
        else if (glitch_evt && glitch_q != '1) glitch_q <= glitch_q + 1'b1;
    end

    assign dbif.glitch_cnt = glitch_q;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Debouncer bench: vector table, hand-written corner sequences and random runs against a run-length model.
module tb_input_debouncer;
    import debounce_pkg::*;

    localparam int SS = DEF_SYNC_STAGES;
    localparam int SC = DEF_STABLE_CYCLES;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    localparam int GW   = 2;
    localparam int GMAX = (1 << GW) - 1;
`endif

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

`ifdef DEBOUNCE_GLITCH_CNT_EN
    input_debouncer_if #(.GLITCH_W(GW)) dbif ();
    input_debouncer #(.SYNC_STAGES(SS), .STABLE_CYCLES(SC), .GLITCH_W(GW)) dut (
`else
    input_debouncer_if dbif ();
    input_debouncer #(.SYNC_STAGES(SS), .STABLE_CYCLES(SC)) dut (
`endif
        .clk    (clk),
        .resetn (resetn),
        .dbif   (dbif)
    );

    int errors = 0;
    int checks = 0;

    // Reference: din delayed by the synchronizer depth, then a run-length count of
    // samples disagreeing with the accepted level.
    logic [SS-1:0] m_dly = '0;
    logic          m_dout = 1'b0;
    int            m_run = 0;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    int            m_gl = 0;
`endif

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic fin;
        if (!resetn) begin
            m_dly = '0; m_dout = 1'b0; m_run = 0;
`ifdef DEBOUNCE_GLITCH_CNT_EN
            m_gl = 0;
`endif
        end else begin
            fin   = m_dly[SS-1];
            m_dly = {m_dly[SS-2:0], dbif.din_async};
            if (fin != m_dout) begin
                m_run++;
                if (m_run == SC) begin
                    m_dout = ~m_dout;
                    m_run  = 0;
                end
            end else begin
`ifdef DEBOUNCE_GLITCH_CNT_EN
                if (m_run > 0 && m_gl < GMAX) m_gl++;
`endif
                m_run = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("model_dout", int'(dbif.dout), int'(m_dout));
        chk("model_busy", int'(dbif.busy), (m_run > 0) ? 1 : 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        chk("model_glitch", int'(dbif.glitch_cnt), m_gl);
`endif
    endtask

    typedef struct {
        logic rstn;
        logic din;
        int   n;
        logic dout;
        logic busy;
    } vec_t;

    vec_t tbl[$];
    int   rises;
    int   rise_at;
    logic prev;
    int   exp_gl[6];

    initial begin
        dbif.din_async = 1'b0;
        resetn = 1'b0;
        @(negedge clk);

        // clean rise / fall, glitch rejection, 15 vs 16 sample boundary, reset in WAIT_LOW
        tbl.push_back('{1'b0, 1'b0, 2,  1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 2,  1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 1,  1'b0, 1'b1});
        tbl.push_back('{1'b1, 1'b1, 14, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 1'b1, 1,  1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 20, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 2,  1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1,  1'b1, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 14, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 1,  1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 2,  1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 2,  1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 1,  1'b0, 1'b1});
        tbl.push_back('{1'b1, 1'b1, 2,  1'b0, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 2,  1'b0, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 1,  1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 38, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 2,  1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 15, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 2,  1'b0, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 1,  1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 5,  1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 16, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 1,  1'b0, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 1,  1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 5,  1'b1, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 1,  1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 17, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 1'b1, 1,  1'b1, 1'b0});

        for (int i = 0; i < tbl.size(); i++) begin
            resetn = tbl[i].rstn;
            dbif.din_async = tbl[i].din;
            repeat (tbl[i].n) tick();
            chk($sformatf("vec%0d_dout", i), int'(dbif.dout), int'(tbl[i].dout));
            chk($sformatf("vec%0d_busy", i), int'(dbif.busy), int'(tbl[i].busy));
`ifdef DEBOUNCE_GLITCH_CNT_EN
            if (i == 16) chk("glitch_reject_cnt", int'(dbif.glitch_cnt), 1);
`endif
        end

        // bounce train: 10 toggles at 3-cycle spacing, then settle high
        resetn = 1'b0; dbif.din_async = 1'b0;
        repeat (2) tick();
        resetn = 1'b1;
        rises = 0; rise_at = -1; prev = dbif.dout;
        for (int t = 0; t < 10; t++) begin
            dbif.din_async = ~dbif.din_async;
            repeat (3) begin
                tick();
                if (!prev && dbif.dout) rises++;
                prev = dbif.dout;
            end
        end
        dbif.din_async = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (!prev && dbif.dout) begin
                rises++;
                rise_at = k;
            end
            prev = dbif.dout;
        end
        chk("bounce_rises", rises, 1);
        chk("bounce_rise_edge", rise_at, SS + SC);

`ifdef DEBOUNCE_GLITCH_CNT_EN
        // counter saturation at 2^GW-1
        exp_gl = '{1, 2, 3, 3, 3, 3};
        resetn = 1'b0; dbif.din_async = 1'b0;
        repeat (2) tick();
        resetn = 1'b1;
        for (int g = 0; g < 6; g++) begin
            dbif.din_async = 1'b1;
            repeat (3) tick();
            dbif.din_async = 1'b0;
            repeat (12) tick();
            chk($sformatf("glitch_sat%0d", g), int'(dbif.glitch_cnt), exp_gl[g]);
        end
`endif

        // random runs of varying length with occasional resets
        resetn = 1'b1;
        for (int r = 0; r < 250; r++) begin
            if ($urandom_range(0, 39) == 0) begin
                resetn = 1'b0;
                repeat ($urandom_range(1, 2)) tick();
                resetn = 1'b1;
            end
            dbif.din_async = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 24)) tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
